conv2_stream: RTL and testbench
===============================

CONV2_STREAM -- requirements
Module: conv2_stream

Interface
REQ-001 SHALL have parameter IMG_W, default 256: input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 256: input image height in pixels.
REQ-003 SHALL have parameter KSIZE, default 3: square kernel side, odd, 1..7.
REQ-004 SHALL have parameter WIDTH_BIT, default 16: signed pixel, coefficient and result width.
REQ-005 SHALL have parameter FRAC_BITS, default 0: result right-shift (fixed-point scaling), 0..WIDTH_BIT-1.
REQ-006 SHALL have port clock  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports kload_valid input 1 and kload_data input WIDTH_BIT: coefficient load, raster order.
REQ-009 SHALL have port start  input  1  one-cycle frame start request.
REQ-010 SHALL have ports in_valid input 1, in_data input WIDTH_BIT, in_ready output 1: raster-order pixel stream.
REQ-011 SHALL have ports out_valid output 1, out_data output WIDTH_BIT, out_ready input 1: result stream.
REQ-012 SHALL have ports busy output 1 (state RUN) and done output 1 (one-cycle end-of-frame pulse).

Function
REQ-013 SHALL implement states IDLE, RUN; IDLE->RUN on start with kernel fully loaded; RUN->IDLE when last result accepted.
REQ-014 SHALL accept one coefficient per cycle with kload_valid in IDLE only; KSIZE*KSIZE words; extra words ignored; kload_valid in RUN ignored.
REQ-015 SHALL ignore start while kernel count < KSIZE*KSIZE or while in RUN.
REQ-016 SHALL drive in_ready = RUN and (not out_valid or out_ready); pixel transfers when in_valid and in_ready.
REQ-017 SHALL hold KSIZE-1 previous image rows in line buffers and form a KSIZE x KSIZE window per accepted pixel.
REQ-018 SHALL emit one result for each accepted pixel at row >= KSIZE-1 and column >= KSIZE-1, total (IMG_H-KSIZE+1)*(IMG_W-KSIZE+1).
REQ-019 SHALL register the result: out_valid rises the cycle after the completing pixel transfers; latency 1.
REQ-020 SHALL hold out_valid and out_data stable until out_ready; no result loss or duplication under backpressure.
REQ-021 SHALL compute full-precision signed sum of products, accumulator width 2*WIDTH_BIT+clog2(KSIZE*KSIZE).
REQ-022 SHALL round half-up (add 2^(FRAC_BITS-1) when FRAC_BITS>0), arithmetic shift right by FRAC_BITS, saturate to signed WIDTH_BIT range.
REQ-023 SHALL wrap column counter at IMG_W-1 to 0 and increment row; row/column counters clear on entering RUN.
REQ-024 SHALL assert done for exactly the cycle the final result transfers; a start in that same cycle is ignored.
REQ-025 SHALL retain kernel across frames; a new start after done reprocesses with the same coefficients.

Reset
REQ-026 SHALL on reset force state IDLE, coefficients and kernel count 0, counters 0, out_valid 0, out_data 0, done 0, busy 0, in_ready 0.
REQ-027 SHALL on reset mid-frame discard all buffered pixels and pending result; kernel reload required before next start.

Configuration
REQ-028 SHALL, when CONV2_STREAM_RELU_EN is defined, clamp negative saturated results to 0 (ReLU); when undefined, pass signed results unchanged.

Structure
REQ-029 SHALL place state enum typedef, accumulator-width constant function and saturate/round function in shared package conv_pkg.
REQ-030 SHALL implement line storage in sub-module conv_line_buffer (parameters IMG_W, KSIZE, WIDTH_BIT; shift-in enable; KSIZE column taps).

Verification (IMG_W=IMG_H=8, KSIZE=3, WIDTH_BIT=16, FRAC_BITS=0 unless stated)
REQ-031 SHALL check all-ones kernel, all-ones image -> 36 results each 9, done pulse on 36th transfer, busy low after.
REQ-032 SHALL check identity kernel (center 1), pixel = 8*r+c -> result[i][j] = 8*(i+1)+(j+1), raster order.
REQ-033 SHALL check kernel all 0x7FFF, pixels 0x7FFF -> 0x7FFF; pixels 0x8000 -> 0x8000; FRAC_BITS=1, sum 3 -> 2.
REQ-034 SHALL check out_ready high one cycle in three -> identical 36-result sequence, in_ready low while out_valid stalled.
REQ-035 SHALL check reset after 20 pixels -> all outputs 0, IDLE; start before kernel reload ignored (busy stays 0).
REQ-036 SHALL check kernel center -1, pixel 5 -> 0 with CONV2_STREAM_RELU_EN, 0xFFFB without.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg -- shared types and arithmetic helpers for the streaming 2-D
// convolution block.
//   state_t    : frame controller states (IDLE, RUN)
//   acc_width  : accumulator width for a KSIZE x KSIZE signed dot product
//   round_sat  : half-up rounding, arithmetic right shift and saturation
//                to a signed width. Works on a wide fixed container so a
//                single function serves every parameterisation. Callers
//                narrow the result with a size cast.
package conv_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int RS_W = 128;

  function automatic int acc_width(input int w, input int k);
    return 2 * w + $clog2(k * k);
  endfunction

  function automatic logic signed [RS_W-1:0] round_sat(
    input logic signed [RS_W-1:0] acc,
    input int                     frac,
    input int                     w
  );
    logic signed [RS_W-1:0] one;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    one = 1;
    r   = acc;
    if (frac > 0) r = r + (one <<< (frac - 1));
    r  = r >>> frac;
    hi = (one <<< (w - 1)) - one;
    lo = -(one <<< (w - 1));
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer -- line storage for a KSIZE x KSIZE sliding window.
// Holds the previous KSIZE-1 image rows as one long shift register that
// advances once per accepted pixel.
// Ports:
//   clock    : rising-edge clock
//   shift_en : advance the line storage (one pixel accepted)
//   din      : incoming pixel
//   taps     : one window column; taps[0] = din (current row),
//              taps[k] = pixel in the same column k rows above
// Pixel data carries no reset: stale contents are never observed because
// results are only produced once KSIZE rows of the frame have entered.
module conv_line_buffer #(
  parameter int IMG_W     = 256,
  parameter int KSIZE     = 3,
  parameter int WIDTH_BIT = 16
) (
  input  logic                        clock,
  input  logic                        shift_en,
  input  logic signed [WIDTH_BIT-1:0] din,
  output logic signed [WIDTH_BIT-1:0] taps [KSIZE]
);

  assign taps[0] = din;

  generate
    if (KSIZE > 1) begin : g_lines
      localparam int DEPTH = (KSIZE - 1) * IMG_W;
      logic signed [WIDTH_BIT-1:0] sr_p0 [DEPTH];

      // Stage p0: line storage, one pixel per accepted transfer
      always_ff @(posedge clock) begin
        if (shift_en) begin
          sr_p0[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr_p0[i] <= sr_p0[i-1];
        end
      end

      // Each full row of delay puts the tap one image row higher.
      for (genvar k = 1; k < KSIZE; k++) begin : g_tap
        assign taps[k] = sr_p0[k*IMG_W-1];
      end
    end
  endgenerate

endmodule

// File: rtl/conv2_stream.sv
// conv2_stream -- streaming KSIZE x KSIZE 2-D convolution (valid region).
// Coefficients are loaded in raster order while idle and kept across
// frames; a start request then processes one IMG_W x IMG_H raster frame.
// Ports:
//   clock, reset            : rising-edge clock, async active-high reset
//   kload_valid, kload_data : coefficient load (IDLE only, KSIZE*KSIZE words)
//   start                   : one-cycle frame start request
//   in_valid/in_data/in_ready    : pixel stream input
//   out_valid/out_data/out_ready : result stream output (latency 1)
//   busy                    : frame in progress
//   done                    : high in the cycle the final result transfers
// Build option: define CONV2_STREAM_RELU_EN to clamp negative results to 0.
module conv2_stream
  import conv_pkg::*;
#(
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int KSIZE     = 3,
  parameter int WIDTH_BIT = 16,
  parameter int FRAC_BITS = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        kload_valid,
  input  logic signed [WIDTH_BIT-1:0] kload_data,
  input  logic                        start,
  input  logic                        in_valid,
  input  logic signed [WIDTH_BIT-1:0] in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic signed [WIDTH_BIT-1:0] out_data,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        done
);

  localparam int KK    = KSIZE * KSIZE;
  localparam int ACC_W = acc_width(WIDTH_BIT, KSIZE);
  localparam int PW    = 2 * WIDTH_BIT;
  localparam int CW    = $clog2(IMG_W + 1);
  localparam int RW    = $clog2(IMG_H + 1);
  localparam int NW    = $clog2(KK + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_EDGE = CW'(KSIZE - 1);
  localparam logic [RW-1:0] ROW_EDGE = RW'(KSIZE - 1);
  localparam logic [NW-1:0] KK_N     = NW'(KK);

  state_t                      state;
  logic [CW-1:0]               col;
  logic [RW-1:0]               row;
  logic [NW-1:0]               kcount;
  logic signed [WIDTH_BIT-1:0] coef [KK];
  logic                        in_done;    // last pixel of frame taken
  logic                        last_pend;  // out register holds final result

  logic signed [WIDTH_BIT-1:0] taps   [KSIZE];
  logic signed [WIDTH_BIT-1:0] win_p0 [KSIZE][KSIZE];
  logic signed [WIDTH_BIT-1:0] nwin   [KSIZE][KSIZE];
  logic signed [ACC_W-1:0]     acc_sum;
  logic signed [WIDTH_BIT-1:0] res_c;

  logic xfer_in;
  logic xfer_out;
  logic emit;
  logic is_last;

  // in_done keeps the frame from swallowing a pixel in the cycle the
  // final result drains.
  assign in_ready = (state == RUN) && !in_done && (!out_valid || out_ready);
  assign xfer_in  = in_valid && in_ready;
  assign xfer_out = out_valid && out_ready;
  assign busy     = (state == RUN);
  assign done     = xfer_out && last_pend;
  assign emit     = (row >= ROW_EDGE) && (col >= COL_EDGE);
  assign is_last  = (row == ROW_LAST) && (col == COL_LAST);

  conv_line_buffer #(
    .IMG_W    (IMG_W),
    .KSIZE    (KSIZE),
    .WIDTH_BIT(WIDTH_BIT)
  ) u_lines (
    .clock   (clock),
    .shift_en(xfer_in),
    .din     (in_data),
    .taps    (taps)
  );

  // Window as it will look once the current pixel's column is shifted in;
  // taps[0] is the bottom (current) row, so window row r takes the tap
  // KSIZE-1-r rows up.
  always_comb begin
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        if (c == KSIZE - 1) nwin[r][c] = taps[KSIZE-1-r];
        else                nwin[r][c] = win_p0[r][c+1];
      end
    end
  end

  always_comb begin
    acc_sum = '0;
    for (int r = 0; r < KSIZE; r++) begin
      for (int c = 0; c < KSIZE; c++) begin
        acc_sum = acc_sum + ACC_W'(PW'(nwin[r][c]) * PW'(coef[r*KSIZE+c]));
      end
    end
  end

  always_comb begin
    res_c = WIDTH_BIT'(round_sat(RS_W'(acc_sum), FRAC_BITS, WIDTH_BIT));
`ifdef CONV2_STREAM_RELU_EN
    if (res_c < 0) res_c = '0;
`endif
  end

  // Stage p0: window register, advances with every accepted pixel
  always_ff @(posedge clock) begin
    if (xfer_in) begin
      for (int r = 0; r < KSIZE; r++) begin
        for (int c = 0; c < KSIZE; c++) win_p0[r][c] <= nwin[r][c];
      end
    end
  end

  // Stage p1: frame control, coefficient store and output register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      kcount    <= '0;
      in_done   <= 1'b0;
      last_pend <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < KK; i++) coef[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (kload_valid && (kcount != KK_N)) begin
            for (int i = 0; i < KK; i++) begin
              if (kcount == NW'(i)) coef[i] <= kload_data;
            end
            kcount <= kcount + NW'(1);
          end
          if (start && (kcount == KK_N)) begin
            state   <= RUN;
            row     <= '0;
            col     <= '0;
            in_done <= 1'b0;
          end
        end
        RUN: begin
          if (xfer_out) begin
            out_valid <= 1'b0;
            if (last_pend) begin
              last_pend <= 1'b0;
              state     <= IDLE;
            end
          end
          if (xfer_in) begin
            if (col == COL_LAST) begin
              col <= '0;
              row <= row + RW'(1);
            end else begin
              col <= col + CW'(1);
            end
            if (is_last) in_done <= 1'b1;
            if (emit) begin
              out_valid <= 1'b1;
              out_data  <= res_c;
              last_pend <= is_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2_stream.sv
module tb_conv2_stream;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        kload_valid;
  logic [15:0] kload_data;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        done;

  // Small instance used for the fixed-point rounding case.
  logic        f_kload_valid;
  logic [15:0] f_kload_data;
  logic        f_start;
  logic        f_in_valid;
  logic [15:0] f_in_data;
  logic        f_in_ready;
  logic        f_out_valid;
  logic [15:0] f_out_data;
  logic        f_out_ready;
  logic        f_busy;
  logic        f_done;

  conv2_stream #(
    .IMG_W(8), .IMG_H(8), .KSIZE(3), .WIDTH_BIT(16), .FRAC_BITS(0)
  ) dut (
    .clock(clock), .reset(reset),
    .kload_valid(kload_valid), .kload_data(kload_data),
    .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  conv2_stream #(
    .IMG_W(3), .IMG_H(3), .KSIZE(3), .WIDTH_BIT(16), .FRAC_BITS(1)
  ) dut_frac (
    .clock(clock), .reset(reset),
    .kload_valid(f_kload_valid), .kload_data(f_kload_data),
    .start(f_start),
    .in_valid(f_in_valid), .in_data(f_in_data), .in_ready(f_in_ready),
    .out_valid(f_out_valid), .out_data(f_out_data), .out_ready(f_out_ready),
    .busy(f_busy), .done(f_done)
  );

  typedef struct {
    logic [15:0] d;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  exp_t f_q[$];
  exp_t mon_e;
  exp_t f_e;
  int   n_tests  = 0;
  int   n_fail   = 0;
  int   rdy_mode = 0;
  int   cyc      = 0;

`ifdef CONV2_STREAM_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Pixel value for a given pattern id at image position (r, c).
  function automatic logic [15:0] pix_of(input int id, input int r, input int c);
    case (id)
      0:       return 16'h0001;
      1:       return 16'(8 * r + c);
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'h0005;
    endcase
  endfunction

  // Hand-derived result for the window whose bottom-right pixel is (r, c).
  function automatic logic [15:0] exp_of(input int id, input int r, input int c);
    case (id)
      0:       return 16'd9;
      1:       return 16'(8 * (r - 1) + (c - 1));
      2:       return 16'h7FFF;
      3:       return RELU ? 16'h0000 : 16'h8000;
      default: return RELU ? 16'h0000 : 16'hFFFB;
    endcase
  endfunction

  // out_ready pattern: always high, or high one cycle in three.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock); #1;
      cyc++;
      out_ready = (rdy_mode == 0) || (cyc % 3 == 0);
    end
  end

  // Scoreboard monitor for the main instance.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h, expected no result", out_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", out_data, mon_e.d);
          check("done_on_transfer", done, mon_e.last);
        end
      end else if (out_valid && !out_ready) begin
        check("in_ready_stall", in_ready, 0);
      end
      if (done && !(out_valid && out_ready)) begin
        n_tests++;
        n_fail++;
        $display("FAIL stray_done: got 1, expected 0");
      end
    end
  end

  // Scoreboard monitor for the rounding instance.
  always @(negedge clock) begin
    if (!reset && f_out_valid && f_out_ready) begin
      if (f_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL frac_unexpected: got %0h, expected no result", f_out_data);
      end else begin
        f_e = f_q.pop_front();
        check("frac_result", f_out_data, f_e.d);
        check("frac_done", f_done, f_e.last);
      end
    end
  end

  task automatic load_kernel(input logic [15:0] k [9]);
    for (int i = 0; i < 9; i++) begin
      kload_valid = 1'b1;
      kload_data  = k[i];
      @(posedge clock); #1;
    end
    kload_data = 16'h0005;  // surplus word, must be ignored
    @(posedge clock); #1;
    kload_valid = 1'b0;
    kload_data  = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [15:0] d);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock); #1;
        break;
      end
      @(posedge clock); #1;
      t++;
      if (t > 200) begin
        check("in_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clock); #1;
      t++;
    end
    check("drain", exp_q.size(), 0);
    @(posedge clock); #1;
    check("busy_after_frame", busy, 0);
  endtask

  task automatic run_frame(input int id);
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        send_pixel(pix_of(id, r, c));
        if (r >= 2 && c >= 2) exp_q.push_back('{d: exp_of(id, r, c), last: (r == 7 && c == 7)});
      end
    end
    in_valid = 1'b0;
    wait_drain();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clock); #1;
    exp_q.delete();
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [15:0] k_ones [9];
    logic [15:0] k_id   [9];
    logic [15:0] k_max  [9];
    logic [15:0] k_neg  [9];
    int t;
    for (int i = 0; i < 9; i++) begin
      k_ones[i] = 16'h0001;
      k_id[i]   = (i == 4) ? 16'h0001 : 16'h0000;
      k_max[i]  = 16'h7FFF;
      k_neg[i]  = (i == 4) ? 16'hFFFF : 16'h0000;
    end

    reset = 1'b1; kload_valid = 1'b0; kload_data = '0; start = 1'b0;
    in_valid = 1'b0; in_data = '0;
    f_kload_valid = 1'b0; f_kload_data = '0; f_start = 1'b0;
    f_in_valid = 1'b0; f_in_data = '0; f_out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;
    @(posedge clock); #1;

    // Start with no kernel loaded is ignored.
    pulse_start();
    check("start_without_kernel", busy, 0);

    // All-ones kernel over an all-ones image.
    load_kernel(k_ones);
    pulse_start();
    check("busy_after_start", busy, 1);
    run_frame(0);

    // Identity kernel, ramp image; then the same frame under backpressure
    // with the kernel retained.
    do_reset();
    load_kernel(k_id);
    pulse_start();
    run_frame(1);
    rdy_mode = 1;
    pulse_start();
    check("restart_retained_kernel", busy, 1);
    run_frame(1);
    rdy_mode = 0;

    // Saturation at both ends.
    do_reset();
    load_kernel(k_max);
    pulse_start();
    run_frame(2);
    pulse_start();
    run_frame(3);

    // Negative centre tap: -5, or 0 with ReLU.
    do_reset();
    load_kernel(k_neg);
    pulse_start();
    run_frame(4);

    // Reset in the middle of a frame.
    do_reset();
    load_kernel(k_ones);
    pulse_start();
    for (int p = 0; p < 20; p++) begin
      send_pixel(16'h0001);
      if ((p / 8) >= 2 && (p % 8) >= 2) exp_q.push_back('{d: 16'd9, last: 1'b0});
    end
    in_valid = 1'b0;
    check("busy_mid_frame", busy, 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("mid_reset");
    exp_q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    pulse_start();
    check("start_after_reset_no_kernel", busy, 0);
    load_kernel(k_ones);
    pulse_start();
    run_frame(0);

    // FRAC_BITS=1: three taps of 1 over ones -> sum 3 -> (3+1)>>1 = 2.
    for (int i = 0; i < 9; i++) begin
      f_kload_valid = 1'b1;
      f_kload_data  = (i < 3) ? 16'h0001 : 16'h0000;
      @(posedge clock); #1;
    end
    f_kload_valid = 1'b0;
    f_start = 1'b1;
    @(posedge clock); #1;
    f_start = 1'b0;
    check("frac_busy", f_busy, 1);
    for (int p = 0; p < 9; p++) begin
      f_in_valid = 1'b1;
      f_in_data  = 16'h0001;
      t = 0;
      @(negedge clock);
      while (!f_in_ready && t < 200) begin
        @(negedge clock);
        t++;
      end
      @(posedge clock); #1;
      if (p == 8) f_q.push_back('{d: 16'h0002, last: 1'b1});
    end
    f_in_valid = 1'b0;
    t = 0;
    while (f_q.size() != 0 && t < 200) begin
      @(posedge clock); #1;
      t++;
    end
    check("frac_drain", f_q.size(), 0);
    @(posedge clock); #1;
    check("frac_busy_after", f_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog timeout");
  end

endmodule
